rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Write-side master for the 3-port register file; owns en4w / addr_w0 / data_i0.
- Merges writeback requests from the ALU and the load/store unit through valid/ready handshakes, with round-robin arbitration on conflict.
- Keeps a per-register busy scoreboard, set by issue and cleared at writeback commit, so the decode stage can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of the register file.
- AW, 5, register address width; the register count is 2**AW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_vld  in  1  ALU writeback request valid.
- alu_rdy  out  1  ALU request accepted this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_vld  in  1  LSU writeback request valid.
- lsu_rdy  out  1  LSU request accepted this cycle.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  load data.
- iss_vld  in  1  decode issues an instruction with a destination register.
- iss_rd  in  AW  destination of the issued instruction.
- en4w  out  1  register-file write enable (registered).
- addr_w0  out  AW  register-file write address (registered).
- data_i0  out  XLEN  register-file write data (registered).
- busy  out  2**AW  scoreboard; bit r=1 means a write to r is in flight.

Behaviour:
- Reset: asynchronous and active-high. While rst=1, en4w, addr_w0, data_i0 and busy are all 0, and last_grant=ALU. Reset asserted mid-operation discards any accepted write not yet committed.
- Handshake: a request transfers in a cycle where vld=1 and rdy=1. The rdy outputs are combinational from the vld inputs and last_grant; they never depend on rdy. A requester holds vld, rd and data stable until accepted.
- Arbitration:
  - Only one valid: that source gets rdy=1.
  - Both valid: grant the source not in last_grant.
  - last_grant updates to the granted source only on a conflict cycle.
  - Neither valid: both rdy=0.
- Latency: a request accepted in cycle N produces en4w=1 with its addr_w0/data_i0 in cycle N+1. The register-file write then occurs at the end of N+1. Back-to-back acceptances give en4w=1 on consecutive cycles.
- No accept in cycle N: en4w=0 in N+1. addr_w0 and data_i0 hold their previous values.
- x0: a request with rd=0 is accepted (rdy=1) but produces en4w=0 in N+1.
- Scoreboard:
  - busy[r] is set at the edge ending a cycle where iss_vld=1 and iss_rd=r≠0.
  - busy[r] is cleared at the edge ending a cycle where en4w=1 and addr_w0=r.
  - Set and clear of the same r in the same cycle: set wins, because a newer producer is in flight.
  - busy[0] is always 0; iss_rd=0 is ignored.
- No internal buffering: throughput is 1 write per cycle; the losing source stalls.
- Widths: no arithmetic. data passes through unmodified at XLEN bits.

Test Plan:
- Reset then single ALU write: alu_vld=1, rd=5, data=0xDEADBEEF in cycle 1 -> alu_rdy=1 in cycle 1; cycle 2 has en4w=1, addr_w0=5, data_i0=0xDEADBEEF; cycle 3 has en4w=0.
- Conflict fairness: both valid for 4 cycles with alu_rd=1..4 and lsu_rd=11..14 -> grants LSU, ALU, LSU, ALU. en4w addresses in cycles 2-5 are 11, 1, 12, 2.
- x0 drop: lsu_vld=1, lsu_rd=0, data=0x1234 -> lsu_rdy=1, en4w stays 0 next cycle, and busy is unchanged.
- Scoreboard:
  - iss_vld=1, iss_rd=7 in cycle 1 -> busy[7]=1 from cycle 2.
  - ALU write to rd=7 accepted in cycle 3 -> en4w=1 in cycle 4, busy[7]=0 from cycle 5.
  - Separately, iss_rd=7 in the same cycle that en4w=1 with addr_w0=7 -> busy[7] stays 1.
- Async reset mid-operation: assert rst between edges while en4w=1 and busy=0x0000_0080 -> en4w=0 and busy=0 immediately, before the next edge. After release, the first conflict grants LSU.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-side master for the 3-port register file: merges ALU and LSU writebacks
// with round-robin arbitration and keeps a per-register busy scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_vld,
  output logic              alu_rdy,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_vld,
  output logic              lsu_rdy,
  input  logic [AW-1:0]     lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              iss_vld,
  input  logic [AW-1:0]     iss_rd,
  output logic              en4w,
  output logic [AW-1:0]     addr_w0,
  output logic [XLEN-1:0]   data_i0,
  output logic [2**AW-1:0]  busy
);

  localparam int NREG = 2**AW;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  src_t            last_grant_reg, last_grant_next;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_en_next;

  logic            en4w_reg;
  logic [AW-1:0]   addr_reg;
  logic [XLEN-1:0] data_reg;
  logic [NREG-1:0] busy_reg, busy_next;

  // Grant state register: remembers who won the most recent conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= SRC_ALU;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // Ready depends only on the valids and the grant history, never on itself.
  always_comb begin
    alu_rdy         = alu_vld && (!lsu_vld || last_grant_reg == SRC_LSU);
    lsu_rdy         = lsu_vld && (!alu_vld || last_grant_reg == SRC_ALU);
    last_grant_next = last_grant_reg;
    if (alu_vld && lsu_vld) begin
      last_grant_next = lsu_rdy ? SRC_LSU : SRC_ALU;
    end
  end

  always_comb begin
    accept     = alu_rdy || lsu_rdy;
    sel_rd     = lsu_rdy ? lsu_rd : alu_rd;
    sel_data   = lsu_rdy ? lsu_data : alu_data;
    // x0 writes are consumed but never reach the register file.
    wr_en_next = accept && (sel_rd != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en4w_reg <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      en4w_reg <= wr_en_next;
      if (wr_en_next) begin
        addr_reg <= sel_rd;
        data_reg <= sel_data;
      end
    end
  end

  // Issue sets after commit clears, so a newer producer keeps the bit high.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        logic set_bit;
        logic clr_bit;
        assign set_bit       = iss_vld && (iss_rd == AW'(gi));
        assign clr_bit       = en4w_reg && (addr_reg == AW'(gi));
        assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign en4w    = en4w_reg;
  assign addr_w0 = addr_reg;
  assign data_i0 = data_reg;
  assign busy    = busy_reg;

endmodule
